// File: rtl/clint.sv
// Core-local interrupt controller: decodes ECALL/EBREAK/external interrupt/MRET,
// then sequences the mepc/mstatus/mcause CSR writes and the PC redirect strobe.
module clint (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  int_flag_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   input  logic [31:0] csr_mstatus,
   input  logic        global_int_en_i,
   output logic        hold_flag_o,
   output logic        we_o,
   output logic [31:0] waddr_o,
   output logic [31:0] data_o,
   output logic [31:0] int_addr_o,
   output logic        int_assert_o,
   output logic [2:0]  dbg_state_o,
   output logic [2:0]  dbg_hold_o
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   typedef enum logic [1:0] {
      INT_IDLE,
      INT_SYNC,
      INT_ASYNC,
      INT_MRET
   } int_req_e;

   typedef enum logic [2:0] {
      CSR_IDLE,
      CSR_MEPC,
      CSR_MSTATUS,
      CSR_MCAUSE,
      CSR_MSTATUS_MRET
   } csr_state_e;

   int_req_e   int_req;
   csr_state_e state_q, state_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] mepc_q, mepc_d;
   logic        we_q, we_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] int_addr_q, int_addr_d;
   logic        int_assert_q, int_assert_d;
   logic [2:0]  dbg_hold_q;

   // Synchronous traps outrank a pending interrupt, which is re-sampled later.
   always_comb begin
      int_req = INT_IDLE;
      if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
         int_req = INT_SYNC;
      end else if (int_flag_i != 8'h00 && global_int_en_i) begin
         int_req = INT_ASYNC;
      end else if (inst_i == INST_MRET) begin
         int_req = INT_MRET;
      end
   end

   assign hold_flag_o = (int_req != INT_IDLE) || (state_q != CSR_IDLE);

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      mepc_d       = mepc_q;
      we_d         = 1'b0;
      waddr_d      = 32'h0;
      data_d       = 32'h0;
      int_addr_d   = 32'h0;
      int_assert_d = 1'b0;
      case (state_q)
         CSR_IDLE: begin
            case (int_req)
               INT_SYNC: begin
                  cause_d = (inst_i == INST_EBREAK) ? 32'd3 : 32'd11;
                  mepc_d  = inst_addr_i;
                  state_d = CSR_MEPC;
               end
               INT_ASYNC: begin
                  cause_d = 32'h8000_0004;
                  mepc_d  = jump_flag_i ? jump_addr_i : inst_addr_i;
                  state_d = CSR_MEPC;
               end
               INT_MRET: state_d = CSR_MSTATUS_MRET;
               default:  state_d = CSR_IDLE;
            endcase
         end
         CSR_MEPC: begin
            we_d    = 1'b1;
            waddr_d = 32'h341;
            data_d  = mepc_q;
            state_d = CSR_MSTATUS;
         end
         CSR_MSTATUS: begin
            we_d    = 1'b1;
            waddr_d = 32'h300;
            data_d  = {csr_mstatus[31:4], 1'b0, csr_mstatus[2:0]};
            state_d = CSR_MCAUSE;
         end
         CSR_MCAUSE: begin
            we_d         = 1'b1;
            waddr_d      = 32'h342;
            data_d       = cause_q;
            int_assert_d = 1'b1;
            int_addr_d   = csr_mtvec;
            state_d      = CSR_IDLE;
         end
         CSR_MSTATUS_MRET: begin
            // MIE is restored from MPIE on return.
            we_d         = 1'b1;
            waddr_d      = 32'h300;
            data_d       = {csr_mstatus[31:4], csr_mstatus[7], csr_mstatus[2:0]};
            int_assert_d = 1'b1;
            int_addr_d   = csr_mepc;
            state_d      = CSR_IDLE;
         end
         default: state_d = CSR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= CSR_IDLE;
         cause_q      <= 32'h0;
         mepc_q       <= 32'h0;
         we_q         <= 1'b0;
         waddr_q      <= 32'h0;
         data_q       <= 32'h0;
         int_addr_q   <= 32'h0;
         int_assert_q <= 1'b0;
         dbg_hold_q   <= 3'h0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         mepc_q       <= mepc_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         data_q       <= data_d;
         int_addr_q   <= int_addr_d;
         int_assert_q <= int_assert_d;
         dbg_hold_q   <= hold_flag_i;
      end
   end

   assign we_o         = we_q;
   assign waddr_o      = waddr_q;
   assign data_o       = data_q;
   assign int_addr_o   = int_addr_q;
   assign int_assert_o = int_assert_q;
   assign dbg_state_o  = state_q;
   assign dbg_hold_o   = dbg_hold_q;

   // mstatus.MIE itself is never forwarded; the written value comes from other bits.
   logic unused_mstatus_mie;
   assign unused_mstatus_mie = csr_mstatus[3];

endmodule

// File: tb/tb_clint.sv
// Bench for clint: vector table of trap/MRET scenarios checked through a
// write/redirect scoreboard, plus reset-mid-sequence and trap-vs-interrupt cases.
module tb_clint;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  int_flag_i = 8'h0;
   logic [31:0] inst_i = 32'h13;
   logic [31:0] inst_addr_i = 32'h0;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = 32'h0;
   logic [2:0]  hold_flag_i = 3'h0;
   logic [31:0] csr_mtvec = 32'h0;
   logic [31:0] csr_mepc = 32'h0;
   logic [31:0] csr_mstatus = 32'h0;
   logic        global_int_en_i = 1'b0;
   logic        hold_flag_o, we_o, int_assert_o;
   logic [31:0] waddr_o, data_o, int_addr_o;
   logic [2:0]  dbg_state_o, dbg_hold_o;

   clint dut (
      .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
      .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .csr_mstatus(csr_mstatus), .global_int_en_i(global_int_en_i),
      .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
      .int_addr_o(int_addr_o), .int_assert_o(int_assert_o),
      .dbg_state_o(dbg_state_o), .dbg_hold_o(dbg_hold_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_wr_q[$];   // {waddr, data}
   logic [39:0] exp_irq_q[$];  // {cycle, int_addr}

   typedef struct {
      logic [31:0]       inst, addr;
      logic [7:0]        intf;
      logic              gie, jf;
      logic [31:0]       ja, mtvec, mepc, mst;
      int                nwr;
      logic [2:0][31:0]  wa, wd;
      logic              irq;
      logic [31:0]       ia;
      int                icyc;
      logic              hold;
      int                busy;
   } vec_t;

   vec_t vt[10];

   function automatic vec_t mk(
      input logic [31:0] inst, input logic [31:0] addr, input logic [7:0] intf,
      input logic gie, input logic jf, input logic [31:0] ja, input logic [31:0] mtvec,
      input logic [31:0] mepc, input logic [31:0] mst, input int nwr,
      input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] a1,
      input logic [31:0] d1, input logic [31:0] a2, input logic [31:0] d2,
      input logic irq, input logic [31:0] ia, input int icyc, input logic hold,
      input int busy);
      vec_t v;
      v.inst = inst; v.addr = addr; v.intf = intf; v.gie = gie; v.jf = jf;
      v.ja = ja; v.mtvec = mtvec; v.mepc = mepc; v.mst = mst; v.nwr = nwr;
      v.wa = {a2, a1, a0}; v.wd = {d2, d1, d0};
      v.irq = irq; v.ia = ia; v.icyc = icyc; v.hold = hold; v.busy = busy;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Samples outputs on falling edges; cycle c counts edges after the request sample edge.
   task automatic observe(input int start, input int n, input int busy_until);
      logic [63:0] e;
      logic [39:0] r;
      int c;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c = start + i;
         if (we_o) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", {waddr_o, data_o}, 64'h0);
            end else begin
               e = exp_wr_q.pop_front();
               check("csr_write", {waddr_o, data_o}, e);
            end
         end else begin
            check("idle_bus", {waddr_o, data_o}, 64'h0);
         end
         if (int_assert_o) begin
            if (exp_irq_q.size() == 0) begin
               check("unexpected_irq", 64'(int_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               r = exp_irq_q.pop_front();
               check("irq_addr", 64'(int_addr_o), 64'(r[31:0]));
               check("irq_cycle", 64'(c), 64'(r[39:32]));
            end
         end else begin
            check("irq_addr_idle", 64'(int_addr_o), 64'h0);
         end
         check("hold_busy", 64'(hold_flag_o), 64'(c < busy_until));
      end
   endtask

   task automatic drain(input string tag);
      check({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'h0);
      check({tag, "_irq_left"}, 64'(exp_irq_q.size()), 64'h0);
      exp_wr_q.delete();
      exp_irq_q.delete();
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      inst_i = v.inst; inst_addr_i = v.addr; int_flag_i = v.intf;
      global_int_en_i = v.gie; jump_flag_i = v.jf; jump_addr_i = v.ja;
      csr_mtvec = v.mtvec; csr_mepc = v.mepc; csr_mstatus = v.mst;
      hold_flag_i = 3'($urandom_range(0, 7));
      for (int k = 0; k < v.nwr; k++) exp_wr_q.push_back({v.wa[k], v.wd[k]});
      if (v.irq) exp_irq_q.push_back({8'(v.icyc), v.ia});
      #1;
      check($sformatf("hold_req_v%0d", idx), 64'(hold_flag_o), 64'(v.hold));
      @(posedge clk);
      #1;
      inst_i = 32'h13; int_flag_i = 8'h0; jump_flag_i = 1'b0;
      observe(0, 6, v.busy);
      drain($sformatf("v%0d", idx));
   endtask

   initial begin
      vt[0] = mk(32'h73, 32'h100, 8'h0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h88, 3,
                 32'h341, 32'h100, 32'h300, 32'h80, 32'h342, 32'd11, 1'b1, 32'h200, 3, 1'b1, 3);
      vt[1] = mk(32'h0010_0073, 32'h204, 8'h0, 1'b0, 1'b0, 32'h0, 32'h1000, 32'h0, 32'h8, 3,
                 32'h341, 32'h204, 32'h300, 32'h0, 32'h342, 32'd3, 1'b1, 32'h1000, 3, 1'b1, 3);
      vt[2] = mk(32'h13, 32'h300, 8'h01, 1'b1, 1'b1, 32'h80, 32'h200, 32'h0, 32'h8, 3,
                 32'h341, 32'h80, 32'h300, 32'h0, 32'h342, 32'h8000_0004, 1'b1, 32'h200, 3, 1'b1, 3);
      vt[3] = mk(32'h13, 32'h310, 8'h80, 1'b1, 1'b0, 32'h999, 32'h240, 32'h0, 32'hFFFF_FFFF, 3,
                 32'h341, 32'h310, 32'h300, 32'hFFFF_FFF7, 32'h342, 32'h8000_0004, 1'b1, 32'h240, 3, 1'b1, 3);
      vt[4] = mk(32'h13, 32'h320, 8'h01, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h88, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 0);
      vt[5] = mk(32'h3020_0073, 32'h400, 8'h0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h104, 32'h80, 1,
                 32'h300, 32'h88, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h104, 1, 1'b1, 1);
      vt[6] = mk(32'h3020_0073, 32'h404, 8'h0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h2000, 32'h8, 1,
                 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h2000, 1, 1'b1, 1);
      vt[7] = mk(32'h13, 32'h408, 8'h0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 32'h88, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 0);
      vt[8] = mk(32'h3020_0073, 32'h40C, 8'hFF, 1'b0, 1'b0, 32'h0, 32'h200, 32'h44, 32'hFFFF_FF7F, 1,
                 32'h300, 32'hFFFF_FF77, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h44, 1, 1'b1, 1);
      vt[9] = mk(32'h73, 32'h500, 8'h0, 1'b0, 1'b1, 32'h600, 32'h300, 32'h0, 32'h0, 3,
                 32'h341, 32'h500, 32'h300, 32'h0, 32'h342, 32'd11, 1'b1, 32'h300, 3, 1'b1, 3);

      repeat (2) @(posedge clk);
      #1;
      check("rst_we", 64'(we_o), 64'h0);
      check("rst_bus", {waddr_o, data_o}, 64'h0);
      check("rst_irq", {31'h0, int_assert_o, int_addr_o}, 64'h0);
      check("rst_hold", 64'(hold_flag_o), 64'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) apply_vec(vt[i], i);

      // Trap and interrupt together: trap first, interrupt taken afterwards.
      @(negedge clk);
      inst_i = 32'h73; inst_addr_i = 32'h400; int_flag_i = 8'h01; global_int_en_i = 1'b1;
      jump_flag_i = 1'b0; csr_mtvec = 32'h200; csr_mstatus = 32'h88;
      exp_wr_q.push_back({32'h341, 32'h400});
      exp_wr_q.push_back({32'h300, 32'h80});
      exp_wr_q.push_back({32'h342, 32'd11});
      exp_irq_q.push_back({8'd3, 32'h200});
      exp_wr_q.push_back({32'h341, 32'h404});
      exp_wr_q.push_back({32'h300, 32'h80});
      exp_wr_q.push_back({32'h342, 32'h8000_0004});
      exp_irq_q.push_back({8'd7, 32'h200});
      @(posedge clk);
      #1;
      inst_i = 32'h13; inst_addr_i = 32'h404;
      observe(0, 4, 7);
      @(posedge clk);
      #1;
      int_flag_i = 8'h0;
      observe(4, 7, 7);
      drain("sync_async");

      // Reset while the mstatus write is pending.
      @(negedge clk);
      inst_i = 32'h73; inst_addr_i = 32'h600; global_int_en_i = 1'b0;
      csr_mtvec = 32'h700; csr_mstatus = 32'h88;
      exp_wr_q.push_back({32'h341, 32'h600});
      exp_wr_q.push_back({32'h300, 32'h80});
      exp_wr_q.push_back({32'h342, 32'd11});
      exp_irq_q.push_back({8'd3, 32'h700});
      @(posedge clk);
      #1;
      inst_i = 32'h13;
      observe(0, 2, 3);
      rst = 1'b0;
      #1;
      check("midrst_we", 64'(we_o), 64'h0);
      check("midrst_bus", {waddr_o, data_o}, 64'h0);
      check("midrst_irq", {31'h0, int_assert_o, int_addr_o}, 64'h0);
      check("midrst_hold", 64'(hold_flag_o), 64'h0);
      exp_wr_q.delete();
      exp_irq_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      observe(0, 6, 0);
      drain("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
